lifo_drain_ctrl: RTL and testbench
==================================

# lifo_drain_ctrl

Read-side controller for the 32-bit stack memory. On a start command it pops a requested number of entries, or all entries, from the stack. It drives the stack's `rd` strobe, absorbs the stack's one-cycle registered read latency in a 3-entry output buffer, and presents the popped words, top of stack first, on a valid/ready stream to downstream logic.

## Interface
Parameters:
- `DATA_W`, 32, stack word width
- `CNT_W`, 10, width of pop count and popped counter (matches the stack pointer width)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle command pulse; ignored while `busy`
- `pop_count`  in  CNT_W  entries to pop, sampled with `start`; 0 = drain until empty
- `busy`  out  1  high from the cycle after accepted `start` through the `done` cycle
- `done`  out  1  one-cycle pulse when the drain finishes
- `popped`  out  CNT_W  words delivered on the stream this drain; holds until next `start`
- `lifo_rd`  out  1  pop strobe to stack `rd`
- `lifo_empty`  in  1  stack empty flag
- `lifo_data`  in  DATA_W  stack `data_out`, valid the cycle after a `lifo_rd` cycle
- `m_valid`  out  1  stream word valid
- `m_ready`  in  1  downstream accept
- `m_data`  out  DATA_W  stream word

## Operation
- FSM states: IDLE, DRAIN, DONE. Reset state is IDLE.
- IDLE → DRAIN when `start`=1. Latch `pop_count` as the target, and clear `issued` and `popped`.
- In DRAIN, `lifo_rd` = `!lifo_empty && (target==0 || issued<target) && (occ + inflight < 3)`.
  - `occ` is the buffer occupancy (0..3).
  - `inflight` is 1 if `lifo_rd` was high in the previous cycle.
  - `lifo_rd` is combinational from registered state and `lifo_empty`.
  - Each `lifo_rd` cycle increments `issued`.
- Capture: when `inflight`=1, `lifo_data` is written to the buffer tail at the end of that cycle.
- Stream output:
  - `m_valid` = (`occ` != 0); `m_data` = buffer head.
  - A pop occurs on `m_valid && m_ready` and increments `popped`.
  - A push and a pop in the same cycle leave `occ` unchanged.
  - Words are delivered in stack pop order (last pushed word first).
- DRAIN → DONE when `inflight`=0, `occ`=0, `lifo_rd`=0, and either `lifo_empty`=1 or `issued`==target (target≠0).
- DONE: `done`=1 for one cycle, then → IDLE.
- Empty stack at start: DRAIN lasts one cycle, then DONE with `popped`=0.
- `pop_count` larger than the stack contents: drain stops at empty; `popped` reports the actual count.
- Counters are CNT_W bits wide. They never wrap because the stack holds at most 512 entries.
- The stack writer must keep `wr` low while `busy`. The block does not check this: a simultaneous stack `wr`/`rd` leaves the stack pointer unchanged and corrupts the stream.
- Reset mid-drain:
  - Returns to IDLE and clears `occ`, `inflight`, `issued`, `popped`.
  - Buffered and in-flight words are discarded, and are already removed from the stack.
  - No `done` pulse.

## Timing
- Reset values: `busy`=0, `done`=0, `popped`=0, `lifo_rd`=0, `m_valid`=0, `m_data`=0.
- `start` high in cycle 0 → `busy`=1 and first `lifo_rd` in cycle 1 → `lifo_data` valid in cycle 2 → `m_valid`=1 in cycle 3.
- With `m_ready` held at 1, `lifo_rd` is high every cycle and the stream carries one word per cycle.
- `m_ready`=0: `occ` reaches 3, `lifo_rd` stops, and no word is lost. `m_data` and `m_valid` stay stable while `m_valid && !m_ready`.
- `done` is high in the cycle after the last stream handshake. `busy` is high in that cycle and low in the next.
- A `start` that arrives in the DONE cycle is ignored.

## Test plan
- Push 0x11, 0x22, 0x33, then `start` with `pop_count`=0 and `m_ready`=1.
  → Stream 0x33, 0x22, 0x11 in cycles 3, 4, 5; `done` in cycle 6; `popped`=3; `lifo_empty`=1.
- Push 5 words, then `start` with `pop_count`=2.
  → Exactly 2 `lifo_rd` pulses; the top 2 words are streamed; `popped`=2; the stack pointer ends at 3.
- Empty stack, `start` with `pop_count`=4.
  → No `lifo_rd`; `m_valid` never asserts; `done` in cycle 2; `popped`=0.
- Push 8 words, then drain with `m_ready` toggling 1, 0, 0, 1, ….
  → `occ` never exceeds 3; all 8 words arrive in reverse push order; `m_data` stays stable while stalled.
- Push 6 words, `start`, assert `rst` in cycle 4, then release.
  → All outputs return to reset values in the next cycle; no `done` pulse; a second `start` drains the remaining entries correctly.

Source files
------------

// File: rtl/lifo_drain_ctrl.sv
// Pops N (or all) words from the stack and streams them top-first; first word valid 3 cycles after start.
// Backpressure: a 3-entry buffer absorbs the stack's read latency, and rd is throttled so the buffer never overflows.
module lifo_drain_ctrl #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  pop_count,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  popped,
    output logic              lifo_rd,
    input  logic              lifo_empty,
    input  logic [DATA_W-1:0] lifo_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data
);

    typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  target;
    logic [CNT_W-1:0]  issued;
    logic [CNT_W-1:0]  popped_q;
    logic              inflight;
    logic [1:0]        occ;
    logic [1:0]        head;
    logic [1:0]        tail;
    logic [DATA_W-1:0] fifo_mem [3];
    logic              rd_en;
    logic              pop;
    logic              finished;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    assign pop = (occ != 2'd0) && m_ready;

    always_comb begin
        rd_en = 1'b0;
        if (state == DRAIN) begin
            rd_en = !lifo_empty
                 && (target == '0 || issued < target)
                 && (({1'b0, occ} + {2'b00, inflight}) < 3'd3);
        end
    end

    // Evaluated on post-update occupancy so done lands the cycle after the last handshake.
    always_comb begin
        finished = !inflight && !rd_en
                && (occ == 2'd0 || (occ == 2'd1 && pop))
                && (lifo_empty || (target != '0 && issued == target));
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)    state_nxt = DRAIN;
            DRAIN:   if (finished) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            target   <= '0;
            issued   <= '0;
            popped_q <= '0;
            inflight <= 1'b0;
            occ      <= 2'd0;
            head     <= 2'd0;
            tail     <= 2'd0;
        end else begin
            state    <= state_nxt;
            inflight <= rd_en;
            if (state == IDLE && start) begin
                target   <= pop_count;
                issued   <= '0;
                popped_q <= '0;
            end else begin
                if (rd_en) issued   <= issued + CNT_W'(1);
                if (pop)   popped_q <= popped_q + CNT_W'(1);
            end
            if (inflight) tail <= ptr_inc(tail);
            if (pop)      head <= ptr_inc(head);
            if (inflight && !pop)      occ <= occ + 2'd1;
            else if (!inflight && pop) occ <= occ - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (inflight) fifo_mem[tail] <= lifo_data;
    end

    assign busy    = (state != IDLE);
    assign done    = (state == DONE);
    assign popped  = popped_q;
    assign lifo_rd = rd_en;
    assign m_valid = (occ != 2'd0);
    assign m_data  = m_valid ? fifo_mem[head] : '0;

endmodule

// File: tb/tb_lifo_drain_ctrl.sv
// Directed bench for lifo_drain_ctrl with a behavioural stack memory (registered read, push/pop pointer).
module tb_lifo_drain_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [9:0]  pop_count = '0;
    logic        busy, done, lifo_rd, m_valid;
    logic [9:0]  popped;
    logic        lifo_empty;
    logic [31:0] lifo_data = '0;
    logic        m_ready = 1'b1;
    logic [31:0] m_data;

    logic        wr = 1'b0;
    logic [31:0] din = '0;
    logic [31:0] mem [512];
    logic [9:0]  sp = '0;

    int vectors = 0;
    int miscompares = 0;

    int rd_cnt, done_cyc, done_cnt, max_out, unstable;
    logic [31:0] words [$];

    always #5 clk = ~clk;

    lifo_drain_ctrl #(.DATA_W(32), .CNT_W(10)) dut (
        .clk(clk), .rst(rst), .start(start), .pop_count(pop_count),
        .busy(busy), .done(done), .popped(popped), .lifo_rd(lifo_rd),
        .lifo_empty(lifo_empty), .lifo_data(lifo_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data)
    );

    // Stack memory: one-cycle registered read on rd, push on wr.
    assign lifo_empty = (sp == 10'd0);
    always @(posedge clk) begin
        if (wr) begin
            mem[sp] <= din;
            sp      <= sp + 10'd1;
        end else if (lifo_rd) begin
            lifo_data <= mem[sp - 10'd1];
            sp        <= sp - 10'd1;
        end
    end

    typedef struct {
        logic        start;
        logic [9:0]  pc;
        logic        rdy;
        logic        busy;
        logic        done;
        logic        rd;
        logic        mv;
        logic [31:0] md;
        logic [9:0]  popped;
    } vec_t;

    vec_t tbl [9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] v);
        wr  = 1'b1;
        din = v;
        tick();
        wr  = 1'b0;
    endtask

    // Runs one drain from a start in cycle 0; records stream words, rd pulses and done timing.
    task automatic drain(input logic [9:0] pc, input bit toggle, input int rst_at);
        int   outstanding;
        logic prev_stall;
        logic [31:0] prev_data;
        rd_cnt = 0; done_cyc = -1; done_cnt = 0; max_out = 0; unstable = 0;
        words.delete();
        prev_stall = 1'b0;
        prev_data  = '0;
        for (int c = 0; c < 60; c++) begin
            start     = (c == 0);
            pop_count = pc;
            m_ready   = toggle ? ((c % 4) == 0 || (c % 4) == 3) : 1'b1;
            rst       = (c == rst_at);
            @(negedge clk);
            outstanding = rd_cnt - int'(words.size());
            if (outstanding > max_out) max_out = outstanding;
            if (prev_stall && (m_valid !== 1'b1 || m_data !== prev_data)) unstable++;
            prev_stall = m_valid && !m_ready && !rst;
            prev_data  = m_data;
            if (lifo_rd) rd_cnt++;
            if (m_valid && m_ready && !rst) words.push_back(m_data);
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (rst_at >= 0 && c == rst_at + 1) begin
                chk("rst busy", {31'd0, busy}, 32'd0);
                chk("rst done", {31'd0, done}, 32'd0);
                chk("rst lifo_rd", {31'd0, lifo_rd}, 32'd0);
                chk("rst m_valid", {31'd0, m_valid}, 32'd0);
                chk("rst m_data", m_data, 32'd0);
                chk("rst popped", {22'd0, popped}, 32'd0);
            end
            tick();
            if (rst_at < 0 && done_cyc >= 0) break;
            if (rst_at >= 0 && c >= rst_at + 3) break;
        end
        start   = 1'b0;
        rst     = 1'b0;
        m_ready = 1'b1;
    endtask

    initial begin
        tbl[0] = '{1'b1, 10'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00, 10'd0};
        tbl[1] = '{1'b0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h00, 10'd0};
        tbl[2] = '{1'b0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h00, 10'd0};
        tbl[3] = '{1'b0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h33, 10'd0};
        tbl[4] = '{1'b0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h22, 10'd1};
        tbl[5] = '{1'b0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h11, 10'd2};
        tbl[6] = '{1'b1, 10'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h00, 10'd3};
        tbl[7] = '{1'b0, 10'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00, 10'd3};
        tbl[8] = '{1'b0, 10'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00, 10'd3};

        rst = 1'b1;
        tick();
        @(negedge clk);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        chk("reset popped", {22'd0, popped}, 32'd0);
        chk("reset lifo_rd", {31'd0, lifo_rd}, 32'd0);
        chk("reset m_valid", {31'd0, m_valid}, 32'd0);
        chk("reset m_data", m_data, 32'd0);
        tick();
        rst = 1'b0;

        // Full drain of three words, with a start in the done cycle that must be ignored.
        push(32'h11); push(32'h22); push(32'h33);
        for (int i = 0; i < 9; i++) begin
            start     = tbl[i].start;
            pop_count = tbl[i].pc;
            m_ready   = tbl[i].rdy;
            @(negedge clk);
            chk($sformatf("t1 c%0d busy", i), {31'd0, busy}, {31'd0, tbl[i].busy});
            chk($sformatf("t1 c%0d done", i), {31'd0, done}, {31'd0, tbl[i].done});
            chk($sformatf("t1 c%0d lifo_rd", i), {31'd0, lifo_rd}, {31'd0, tbl[i].rd});
            chk($sformatf("t1 c%0d m_valid", i), {31'd0, m_valid}, {31'd0, tbl[i].mv});
            if (tbl[i].mv) chk($sformatf("t1 c%0d m_data", i), m_data, tbl[i].md);
            chk($sformatf("t1 c%0d popped", i), {22'd0, popped}, {22'd0, tbl[i].popped});
            tick();
        end
        start = 1'b0;
        chk("t1 lifo_empty", {31'd0, lifo_empty}, 32'd1);

        // Empty stack with a nonzero count.
        drain(10'd4, 1'b0, -1);
        chk("t3 rd pulses", rd_cnt, 0);
        chk("t3 words", words.size(), 0);
        chk("t3 done cycle", done_cyc, 2);
        chk("t3 popped", {22'd0, popped}, 32'd0);

        // Partial drain of the top two of five.
        for (int i = 0; i < 5; i++) push(32'hB0 + i);
        drain(10'd2, 1'b0, -1);
        chk("t2 rd pulses", rd_cnt, 2);
        chk("t2 words", words.size(), 2);
        for (int k = 0; k < 2 && k < words.size(); k++)
            chk($sformatf("t2 word%0d", k), words[k], 32'hB4 - k);
        chk("t2 done cycle", done_cyc, 5);
        chk("t2 popped", {22'd0, popped}, 32'd2);
        chk("t2 sp", {22'd0, sp}, 32'd3);

        // Remaining three, count larger than contents.
        drain(10'd9, 1'b0, -1);
        chk("t2b words", words.size(), 3);
        for (int k = 0; k < 3 && k < words.size(); k++)
            chk($sformatf("t2b word%0d", k), words[k], 32'hB2 - k);
        chk("t2b popped", {22'd0, popped}, 32'd3);
        chk("t2b empty", {31'd0, lifo_empty}, 32'd1);

        // Eight words under a stalling consumer.
        for (int i = 0; i < 8; i++) push(32'hD0 + i);
        drain(10'd0, 1'b1, -1);
        chk("t4 done seen", {31'd0, done_cyc >= 0}, 32'd1);
        chk("t4 words", words.size(), 8);
        for (int k = 0; k < 8 && k < words.size(); k++)
            chk($sformatf("t4 word%0d", k), words[k], 32'hD7 - k);
        chk("t4 outstanding<=3", {31'd0, max_out <= 3}, 32'd1);
        chk("t4 stall stability", unstable, 0);
        chk("t4 popped", {22'd0, popped}, 32'd8);

        // Reset in cycle 4 of a six-word drain; four words have already left the stack.
        for (int i = 0; i < 6; i++) push(32'hC0 + i);
        drain(10'd0, 1'b0, 4);
        chk("t5 done pulses", done_cnt, 0);
        chk("t5 pre-reset words", words.size(), 1);
        chk("t5 sp after reset", {22'd0, sp}, 32'd2);
        drain(10'd0, 1'b0, -1);
        chk("t5 words", words.size(), 2);
        for (int k = 0; k < 2 && k < words.size(); k++)
            chk($sformatf("t5 word%0d", k), words[k], 32'hC1 - k);
        chk("t5 popped", {22'd0, popped}, 32'd2);
        chk("t5 empty", {31'd0, lifo_empty}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
